// File: rtl/motoro_pkg.sv
// Shared types, step-pattern table and default parameters for the motoro six-step drive.
package motoro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } motorStateT;

  localparam int unsigned DEF_TICK_DIV = 50;
  localparam int unsigned DEF_STEP_MOD = 1_000_000;
  localparam int unsigned DEF_DEAD_CYC = 50;
  localparam int unsigned DEF_HB_DIV   = 25_000_000;
  localparam int unsigned DEF_BAUD_DIV = 434;

  // Bit order {aHP, bHP, cHP, aLN, bLN, cLN}
  localparam logic [5:0] STEP_PATTERN [6] = '{
    6'b100_010,
    6'b100_001,
    6'b010_001,
    6'b010_100,
    6'b001_100,
    6'b001_010
  };

  function automatic logic [2:0] nextStep(input logic [2:0] step, input logic reverse);
    if (reverse) return (step == 3'd0) ? 3'd5 : step - 3'd1;
    else         return (step == 3'd5) ? 3'd0 : step + 3'd1;
  endfunction

endpackage

// File: rtl/motoro_uart_tx.sv
// 8N1 transmitter, LSB first; a request while busy is ignored.
module motoro_uart_tx
  import motoro_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned BW = $clog2(BAUD_DIV + 1);

  logic [BW-1:0] baudCnt;
  logic [3:0]    bitIdx;
  logic [8:0]    shReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      baudCnt <= '0;
      bitIdx  <= '0;
      shReg   <= '1;
    end else if (!busy) begin
      if (valid) begin
        busy    <= 1'b1;
        tx      <= 1'b0;
        shReg   <= {1'b1, data};
        bitIdx  <= '0;
        baudCnt <= '0;
      end
    end else if (baudCnt == BW'(BAUD_DIV - 1)) begin
      baudCnt <= '0;
      if (bitIdx == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        tx     <= shReg[0];
        shReg  <= {1'b1, shReg[8:1]};
        bitIdx <= bitIdx + 4'd1;
      end
    end else begin
      baudCnt <= baudCnt + 1'b1;
    end
  end

endmodule

// File: rtl/motoro_3ph_drive.sv
// Six-step BLDC commutation with dead time, fault latch and heartbeat.
// Optional step-report UART enabled by defining MOTORO_UART_EN.
module motoro_3ph_drive
  import motoro_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned STEP_MOD = DEF_STEP_MOD,
  parameter int unsigned DEAD_CYC = DEF_DEAD_CYC,
  parameter int unsigned HB_DIV   = DEF_HB_DIV,
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk50mhz,
  input  logic       nReset,
  input  logic       m3start,
  input  logic       m3forceStop,
  input  logic       m3invRotate,
  input  logic [9:0] m3freq,
  output logic       aHP,
  output logic       bHP,
  output logic       cHP,
  output logic       aLN,
  output logic       bLN,
  output logic       cLN,
  output logic       tp01,
  output logic       tp02,
  output logic       uTx,
  output logic [3:0] led4
);

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned HW = $clog2(HB_DIV + 1);
  localparam int unsigned DW = $clog2(DEAD_CYC + 1);

  motorStateT    state;
  logic [TW-1:0] tickCnt;
  logic [HW-1:0] hbCnt;
  logic [DW-1:0] deadCnt;
  logic [20:0]   acc;
  logic [20:0]   accSum;
  logic [2:0]    step;
  logic [2:0]    stepNext;
  logic          paused;
  logic          hbLed;
  logic          invReg;
  logic          tick;
  logic          advance;
  logic          driveOn;
  logic [5:0]    drives;

  assign tick     = (tickCnt == TW'(TICK_DIV - 1));
  assign accSum   = acc + 21'(m3freq) * 21'd6;
  assign stepNext = nextStep(step, m3invRotate);
  assign advance  = (state == RUN) && !m3forceStop && m3start && (m3freq != '0)
                    && tick && (accSum >= 21'(STEP_MOD));

  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      state   <= IDLE;
      tickCnt <= '0;
      hbCnt   <= '0;
      hbLed   <= 1'b0;
      deadCnt <= '0;
      acc     <= '0;
      step    <= '0;
      paused  <= 1'b0;
      invReg  <= 1'b0;
      tp01    <= 1'b0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + 1'b1;
      if (hbCnt == HW'(HB_DIV - 1)) begin
        hbCnt <= '0;
        hbLed <= ~hbLed;
      end else begin
        hbCnt <= hbCnt + 1'b1;
      end
      invReg <= m3invRotate;
      tp01   <= advance;
      if (deadCnt != '0) deadCnt <= deadCnt - 1'b1;

      if (m3forceStop) begin
        state   <= FAULT;
        paused  <= 1'b0;
        deadCnt <= '0;
      end else begin
        case (state)
          IDLE: if (m3start) begin
            state   <= RUN;
            step    <= '0;
            acc     <= '0;
            paused  <= 1'b0;
            deadCnt <= DW'(DEAD_CYC);
          end
          RUN: if (!m3start) begin
            state   <= IDLE;
            paused  <= 1'b0;
            deadCnt <= '0;
          end else if (m3freq == '0) begin
            paused <= 1'b1;
          end else begin
            // Resume from a zero-frequency pause and a step advance both (re)start dead time.
            if (paused) begin
              paused  <= 1'b0;
              deadCnt <= DW'(DEAD_CYC);
            end
            if (advance) begin
              acc     <= accSum - 21'(STEP_MOD);
              step    <= stepNext;
              deadCnt <= DW'(DEAD_CYC);
            end else if (tick) begin
              acc <= accSum;
            end
          end
          FAULT: if (!m3start) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign driveOn = (state == RUN) && !paused && (deadCnt == '0);
  assign drives  = driveOn ? STEP_PATTERN[step] : '0;
  assign {aHP, bHP, cHP, aLN, bLN, cLN} = drives;
  assign tp02    = (deadCnt != '0);
  assign led4    = {hbLed, invReg, state == FAULT, state == RUN};

`ifdef MOTORO_UART_EN
  logic       txValid;
  logic       txBusy;
  logic [7:0] txByte;

  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      txValid <= 1'b0;
      txByte  <= '0;
    end else begin
      txValid <= advance && !txBusy;
      txByte  <= 8'h30 + 8'(stepNext);
    end
  end

  motoro_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) uUart (
    .clk  (clk50mhz),
    .rst  (nReset),
    .data (txByte),
    .valid(txValid),
    .busy (txBusy),
    .tx   (uTx)
  );
`else
  assign uTx = 1'b1;
`endif

endmodule

// File: tb/tb_motoro_3ph_drive.sv
// Directed bench for motoro_3ph_drive with scaled-down timing parameters.
module tb_motoro_3ph_drive;

  localparam int unsigned TICK_DIV = 5;
  localparam int unsigned STEP_MOD = 10000;
  localparam int unsigned DEAD_CYC = 12;
  localparam int unsigned HB_DIV   = 100;
  localparam int unsigned BAUD_DIV = 8;

  logic       clk50mhz = 1'b0;
  logic       nReset = 1'b1;
  logic       m3start = 1'b0;
  logic       m3forceStop = 1'b0;
  logic       m3invRotate = 1'b0;
  logic [9:0] m3freq = '0;
  logic       aHP, bHP, cHP, aLN, bLN, cLN;
  logic       tp01, tp02, uTx;
  logic [3:0] led4;
  logic [5:0] drv;

  int checks = 0;
  int errors = 0;
  int shoot = 0;
  int cycNow = 0;

  // {aHP, bHP, cHP, aLN, bLN, cLN}
  localparam logic [5:0] PAT [6] = '{6'b100010, 6'b100001, 6'b010001,
                                     6'b010100, 6'b001100, 6'b001010};

  typedef struct {
    logic       start;
    logic       fstop;
    logic       inv;
    logic [9:0] freq;
    int         cyc;
    logic [5:0] expDrv;
    logic [2:0] expLed;
    logic       expTp02;
  } vecT;

  vecT vecs [13];

  motoro_3ph_drive #(
    .TICK_DIV(TICK_DIV),
    .STEP_MOD(STEP_MOD),
    .DEAD_CYC(DEAD_CYC),
    .HB_DIV  (HB_DIV),
    .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk50mhz   (clk50mhz),
    .nReset     (nReset),
    .m3start    (m3start),
    .m3forceStop(m3forceStop),
    .m3invRotate(m3invRotate),
    .m3freq     (m3freq),
    .aHP        (aHP),
    .bHP        (bHP),
    .cHP        (cHP),
    .aLN        (aLN),
    .bLN        (bLN),
    .cLN        (cLN),
    .tp01       (tp01),
    .tp02       (tp02),
    .uTx        (uTx),
    .led4       (led4)
  );

  always #10 clk50mhz = ~clk50mhz;

  assign drv = {aHP, bHP, cHP, aLN, bLN, cLN};

  always @(negedge clk50mhz) begin
    cycNow <= cycNow + 1;
    if ((aHP && aLN) || (bHP && bLN) || (cHP && cLN)) shoot <= shoot + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    nReset = 1'b1;
    m3start = 1'b0;
    m3forceStop = 1'b0;
    m3invRotate = 1'b0;
    m3freq = '0;
    repeat (2) @(negedge clk50mhz);
    nReset = 1'b0;
  endtask

  task automatic waitAdvance(input int bound, input string name, output int waited, output logic ok);
    waited = 0;
    do begin
      @(negedge clk50mhz);
      waited++;
    end while (!tp01 && waited < bound);
    ok = tp01;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no tp01 within %0d cycles", name, bound);
    end
  endtask

  // Walks nAdv advances from step 0, checking order, dead-time length and pattern.
  task automatic runSequence(input logic inv, input int nAdv, input string tag);
    int   waited, deadLen, expStep, lastAdv, iv;
    logic ok, allOff;
    expStep = 0;
    lastAdv = 0;
    for (int k = 0; k < nAdv; k++) begin
      waitAdvance(200, {tag, "_timeout"}, waited, ok);
      if (!ok) return;
      if (k > 0) begin
        iv = cycNow - lastAdv;
        check({tag, "_interval_ok"}, int'(iv == 80 || iv == 85), 1);
      end
      lastAdv = cycNow;
      expStep = inv ? (expStep + 5) % 6 : (expStep + 1) % 6;
      deadLen = 0;
      allOff  = 1'b1;
      while (tp02 && deadLen < 100) begin
        if (drv != '0) allOff = 1'b0;
        deadLen++;
        @(negedge clk50mhz);
      end
      check({tag, "_dead_len"}, deadLen, DEAD_CYC);
      check({tag, "_dead_off"}, int'(allOff), 1);
      check({tag, "_pattern"}, int'(drv), int'(PAT[expStep]));
    end
  endtask

  initial begin
    int   waited, cnt, onCnt;
    logic ok, uartOn;
    logic [9:0] frame;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'd0,   5,  6'b000000, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 10'd0,   5,  6'b000000, 3'b010, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'd0,   5,  6'b000000, 3'b010, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'd0,   3,  6'b000000, 3'b000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'd100, 3,  6'b000000, 3'b001, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'd100, 15, 6'b100010, 3'b001, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'd0,   5,  6'b000000, 3'b001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 10'd100, 3,  6'b000000, 3'b001, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10'd100, 15, 6'b100010, 3'b001, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10'd100, 1,  6'b000000, 3'b000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10'd0,   2,  6'b000000, 3'b100, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 10'd0,   1,  6'b000000, 3'b110, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 10'd0,   2,  6'b000000, 3'b000, 1'b0};

    @(negedge clk50mhz);
    doReset();
    check("reset_drv", int'(drv), 0);
    check("reset_led", int'(led4), 0);
    check("reset_tp", int'({tp01, tp02}), 0);
    check("reset_utx", int'(uTx), 1);

    repeat (99) @(negedge clk50mhz);
    check("hb_before", int'(led4[3]), 0);
    @(negedge clk50mhz);
    check("hb_toggle", int'(led4[3]), 1);

    for (int i = 0; i < 13; i++) begin
      m3start     = vecs[i].start;
      m3forceStop = vecs[i].fstop;
      m3invRotate = vecs[i].inv;
      m3freq      = vecs[i].freq;
      repeat (vecs[i].cyc) @(negedge clk50mhz);
      check($sformatf("vec%0d_drv", i), int'(drv), int'(vecs[i].expDrv));
      check($sformatf("vec%0d_led", i), int'(led4[2:0]), int'(vecs[i].expLed));
      check($sformatf("vec%0d_tp02", i), int'(tp02), int'(vecs[i].expTp02));
    end

    // Forward rotation: first advance latency, then 14 advances with wrap.
    doReset();
    m3freq = 10'd100;
    m3start = 1'b1;
    waitAdvance(200, "fwd_first", waited, ok);
    if (ok) begin
      check("fwd_first_latency", int'(waited >= 80 && waited <= 90), 1);
      doReset();
      m3freq = 10'd100;
      m3start = 1'b1;
      runSequence(1'b0, 14, "fwd");
    end

    // Reverse rotation.
    doReset();
    m3invRotate = 1'b1;
    m3freq = 10'd100;
    m3start = 1'b1;
    runSequence(1'b1, 4, "rev");
    check("rev_led2", int'(led4[2]), 1);

    // Forced stop mid-run and re-arm.
    check("fs_pre_on", int'(drv != '0), 1);
    m3forceStop = 1'b1;
    @(negedge clk50mhz);
    check("fs_drv_off", int'(drv), 0);
    check("fs_led", int'(led4[1:0]), 2);
    m3forceStop = 1'b0;
    repeat (5) @(negedge clk50mhz);
    check("fs_hold_fault", int'(led4[1:0]), 2);
    m3start = 1'b0;
    repeat (2) @(negedge clk50mhz);
    check("fs_idle", int'(led4[1:0]), 0);
    m3start = 1'b1;
    repeat (2) @(negedge clk50mhz);
    check("fs_rerun", int'(led4[1:0]), 1);

    // Zero frequency pause, then full-scale frequency.
    repeat (20) @(negedge clk50mhz);
    m3freq = 10'd0;
    cnt = 0;
    onCnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk50mhz);
      if (tp01) cnt++;
      if (drv != '0) onCnt++;
    end
    check("f0_no_advance", cnt, 0);
    check("f0_drives_off", onCnt, 0);
    check("f0_still_run", int'(led4[0]), 1);
    m3freq = 10'd1023;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50mhz);
      if (tp01) cnt++;
    end
    check("f1023_adv_count", int'(cnt >= 24 && cnt <= 25), 1);
    check("f1023_dead_restart", int'(tp02), 1);

    // Step report on the first advance (0 -> 1).
`ifdef MOTORO_UART_EN
    uartOn = 1'b1;
`else
    uartOn = 1'b0;
`endif
    frame = {1'b1, 8'h31, 1'b0};
    doReset();
    m3freq = 10'd100;
    m3start = 1'b1;
    waitAdvance(200, "uart_adv", waited, ok);
    if (ok) begin
      cnt = 0;
      for (int b = 0; b < 10; b++) begin
        while (cnt < 4 + 8 * b) begin
          @(negedge clk50mhz);
          cnt++;
        end
        check($sformatf("uart_bit%0d", b), int'(uTx), uartOn ? int'(frame[b]) : 1);
      end
    end

    check("no_shoot_through", shoot, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/motoro_3ph_drive.md
Name: motoro_3ph_drive

Overview:
- Top-level three-phase BLDC six-step commutation controller for the 50 MHz board.
- Generates six gate-drive signals (high-side HP / low-side LN per phase) at a commanded electrical frequency with break-before-make dead time.
- Supports start, forced stop and direction reversal.
- Drives status LEDs and two test points; an optional UART reports the commutation step.

Parameters:
TICK_DIV, 50, clk cycles per 1 µs timebase tick
STEP_MOD, 1_000_000, accumulator modulus (ticks per second)
DEAD_CYC, 50, dead-time cycles with all six drives off at each step change
HB_DIV, 25_000_000, clk cycles per heartbeat LED toggle
BAUD_DIV, 434, clk cycles per UART bit (115200 baud)

Ports:
clk50mhz  in  1  50 MHz system clock
nReset  in  1  synchronous reset, active-high (1 = reset); name kept for board-pin compatibility
m3start  in  1  level: 1 = run, 0 = stop
m3forceStop  in  1  emergency stop, overrides everything
m3invRotate  in  1  0 = forward step order, 1 = reverse
m3freq  in  10  electrical frequency in Hz, 0..1023
aHP,bHP,cHP  out  1  high-side switch on (active-high)
aLN,bLN,cLN  out  1  low-side switch on (active-high)
tp01  out  1  one-cycle pulse on each step advance
tp02  out  1  high while dead time is active
uTx  out  1  UART TX, idle high
led4  out  4  [0] running, [1] fault latched, [2] m3invRotate, [3] heartbeat

Behaviour:
- Reset: all six drives 0, tp01/tp02 0, uTx 1, led4 0, state IDLE, step 0, accumulator 0, tick counter 0.
- Timebase: counter 0..TICK_DIV-1; one-cycle tick when it wraps.
- Accumulator: 21-bit. On each tick in RUN, add 6*m3freq (m3freq sampled at that tick).
  - If sum >= STEP_MOD: subtract STEP_MOD and advance the step.
  - Steps advance at 6*m3freq per second.
  - At most one advance per tick.
- Step advance: step = (step+1) mod 6 when m3invRotate=0, (step+5) mod 6 when 1. Direction changes apply at the next advance.
- Step patterns, only these drives on:
  - 0: aHP, bLN
  - 1: aHP, cLN
  - 2: bHP, cLN
  - 3: bHP, aLN
  - 4: cHP, aLN
  - 5: cHP, bLN
- HP and LN of the same phase are never both 1.
- Dead time: on every step change and on RUN entry, all drives go 0 for DEAD_CYC cycles (tp02=1), then the new pattern is applied. A step advance during dead time restarts the dead time with the newest step.
- States:
  - IDLE: drives off. m3start=1 and m3forceStop=0 -> RUN with step 0, acc 0, dead time started.
  - RUN: m3start=0 -> IDLE next cycle, drives off same edge. m3freq=0 -> drives off, acc and step hold, stay RUN; a nonzero freq resumes via dead time.
  - FAULT: entered from any state when m3forceStop=1; drives off on the same clock edge, led4[1]=1. Exit to IDLE only when m3forceStop=0 and m3start=0 (re-arm required).
- led4[0]=1 in RUN. led4[3] toggles every HB_DIV cycles from reset.
- Reset mid-operation: returns everything to reset values on the next edge, no dead-time wait needed since drives go 0.

Optional Feature:
- Macro MOTORO_UART_EN.
- Defined: on each step advance, if the transmitter is idle, send the ASCII byte '0'+step as 8N1 at BAUD_DIV clocks/bit, LSB first. If busy, the report is dropped.
- Undefined: uTx constant 1 and no UART logic is instantiated.

Decomposition:
- Package motoro_pkg:
  - state enum (IDLE, RUN, FAULT)
  - 6-entry step-pattern constant table
  - parameter defaults
- One sub-module: motoro_uart_tx (byte in, valid, busy, tx), instantiated only under MOTORO_UART_EN.

Test Plan:
- Pulse nReset=1, then m3freq=100, m3start=1 -> after dead time of 50 cycles, aHP=bLN=1. First tp01 at 1667 µs ticks (~1.667 ms). Then steps 1,2,3… at ~1.667 ms intervals; 14 advances within 24 ms.
- At each step change, tp02=1 for exactly 50 cycles with all drives 0. Never HP&LN of the same phase simultaneously (assert every cycle).
- m3invRotate=1 at m3freq=100 -> step sequence 0,5,4,3…; led4[2]=1.
- m3forceStop=1 mid-run -> all drives 0 on next edge, led4[1]=1. Release forceStop with m3start=1 -> stays FAULT. Then m3start=0 -> IDLE; m3start=1 -> RUN.
- m3freq=0 in RUN -> drives 0, no tp01. Set m3freq=1023 -> advance every ~163 µs.
- With MOTORO_UART_EN and m3freq=100, step 1 -> uTx frame 0x31: start bit 0, bits LSB-first, stop 1, 434 clk/bit.
